// File: rtl/writeback.sv
// writeback: retires one execute-stage result per instruction as a register
// write, a memory write, or a one/two-byte stack push, then pulses
// instruction_done so the fetcher can start the next instruction.
module writeback #(
  parameter int                    REG_WIDTH  = 8,
  parameter int                    ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100
) (
  input  logic                   phi1,
  input  logic                   reset,
  input  logic                   wb_start,
  input  logic [1:0]             wb_mode,
  input  logic [3:0]             wb_dest,
  input  logic [ADDR_WIDTH-1:0]  wb_addr,
  input  logic [2*REG_WIDTH-1:0] wb_data,
  input  logic [REG_WIDTH-1:0]   sp_in,
  output logic                   wb_ready,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [REG_WIDTH-1:0]   mem_data,
  output logic                   mem_we,
  output logic [3:0]             reg_sel,
  output logic [REG_WIDTH-1:0]   reg_data,
  output logic                   reg_we,
  output logic [REG_WIDTH-1:0]   sp_out,
  output logic                   sp_we,
  output logic                   instruction_done
);

  localparam logic [1:0] MODE_REG    = 2'd0;
  localparam logic [1:0] MODE_MEM    = 2'd1;
  localparam logic [1:0] MODE_PUSH8  = 2'd2;
  localparam logic [1:0] MODE_PUSH16 = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_W_REG, S_W_MEM, S_PUSH_HI, S_PUSH_LO, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [3:0]               dest_q, dest_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [2*REG_WIDTH-1:0]   data_q, data_d;
  logic [REG_WIDTH-1:0]     sp_q, sp_d;
  logic [ADDR_WIDTH-1:0]    stack_addr;

  // SP moves downward and wraps within its own width.
  function automatic logic [REG_WIDTH-1:0] sp_dec(input logic [REG_WIDTH-1:0] v);
    return v - {{(REG_WIDTH-1){1'b0}}, 1'b1};
  endfunction

  // High byte pinned to the stack page, so a push can never leave it.
  assign stack_addr = {STACK_BASE[ADDR_WIDTH-1:REG_WIDTH], sp_q};

  // Next-state and operand latching; operands only change on accept.
  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    addr_d  = addr_q;
    data_d  = data_q;
    sp_d    = sp_q;
    case (state_q)
      S_IDLE: begin
        if (wb_start) begin
          dest_d = wb_dest;
          addr_d = wb_addr;
          data_d = wb_data;
          sp_d   = sp_in;
          case (wb_mode)
            MODE_REG:    state_d = S_W_REG;
            MODE_MEM:    state_d = S_W_MEM;
            MODE_PUSH8:  state_d = S_PUSH_LO;
            MODE_PUSH16: state_d = S_PUSH_HI;
            default:     state_d = S_IDLE;
          endcase
        end
      end
      S_W_REG:   state_d = S_DONE;
      S_W_MEM:   state_d = S_DONE;
      S_PUSH_HI: begin
        sp_d    = sp_dec(sp_q);
        state_d = S_PUSH_LO;
      end
      S_PUSH_LO: state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // State register; operand registers carry no reset since every use is
  // gated by a state that can only be reached through an accept.
  always_ff @(posedge phi1) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
    dest_q <= dest_d;
    addr_q <= addr_d;
    data_q <= data_d;
    sp_q   <= sp_d;
  end

  // Output decode from the registered state; buses read zero when idle.
  always_comb begin
    wb_ready         = (state_q == S_IDLE);
    mem_addr         = '0;
    mem_data         = '0;
    mem_we           = 1'b0;
    reg_sel          = '0;
    reg_data         = '0;
    reg_we           = 1'b0;
    sp_out           = '0;
    sp_we            = 1'b0;
    instruction_done = 1'b0;
    case (state_q)
      S_W_REG: begin
        reg_we   = 1'b1;
        reg_sel  = dest_q;
        reg_data = data_q[REG_WIDTH-1:0];
      end
      S_W_MEM: begin
        mem_we   = 1'b1;
        mem_addr = addr_q;
        mem_data = data_q[REG_WIDTH-1:0];
      end
      S_PUSH_HI: begin
        mem_we   = 1'b1;
        mem_addr = stack_addr;
        mem_data = data_q[2*REG_WIDTH-1:REG_WIDTH];
      end
      S_PUSH_LO: begin
        mem_we   = 1'b1;
        mem_addr = stack_addr;
        mem_data = data_q[REG_WIDTH-1:0];
        sp_we    = 1'b1;
        sp_out   = sp_dec(sp_q);
      end
      S_DONE:  instruction_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_writeback.sv
// tb_writeback: directed table of writeback transactions with per-cycle
// expected outputs, plus hand sequences for reset and overlap corner cases.
module tb_writeback;

  logic        phi1 = 1'b0;
  logic        reset;
  logic        wb_start;
  logic [1:0]  wb_mode;
  logic [3:0]  wb_dest;
  logic [15:0] wb_addr;
  logic [15:0] wb_data;
  logic [7:0]  sp_in;
  logic        wb_ready;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic        mem_we;
  logic [3:0]  reg_sel;
  logic [7:0]  reg_data;
  logic        reg_we;
  logic [7:0]  sp_out;
  logic        sp_we;
  logic        instruction_done;

  writeback dut (
    .phi1(phi1), .reset(reset), .wb_start(wb_start), .wb_mode(wb_mode),
    .wb_dest(wb_dest), .wb_addr(wb_addr), .wb_data(wb_data), .sp_in(sp_in),
    .wb_ready(wb_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_we(mem_we), .reg_sel(reg_sel), .reg_data(reg_data), .reg_we(reg_we),
    .sp_out(sp_out), .sp_we(sp_we), .instruction_done(instruction_done)
  );

  always #5 phi1 = ~phi1;

  typedef struct packed {
    logic        ready;
    logic        mwe;
    logic [15:0] maddr;
    logic [7:0]  mdata;
    logic        rwe;
    logic [3:0]  rsel;
    logic [7:0]  rdata;
    logic        spwe;
    logic [7:0]  spo;
    logic        done;
  } out_t;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  dest;
    logic [15:0] addr;
    logic [15:0] data;
    logic [7:0]  sp;
    out_t        exp [4];
  } vec_t;

  localparam int NV = 8;
  vec_t vecs [NV];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic out_t o_idle();
    return '{ready:1'b1, mwe:1'b0, maddr:16'h0, mdata:8'h0, rwe:1'b0,
             rsel:4'h0, rdata:8'h0, spwe:1'b0, spo:8'h0, done:1'b0};
  endfunction
  function automatic out_t o_done();
    out_t o = o_idle(); o.ready = 1'b0; o.done = 1'b1; return o;
  endfunction
  function automatic out_t o_reg(input logic [3:0] s, input logic [7:0] d);
    out_t o = o_idle(); o.ready = 1'b0; o.rwe = 1'b1; o.rsel = s; o.rdata = d; return o;
  endfunction
  function automatic out_t o_mem(input logic [15:0] a, input logic [7:0] d);
    out_t o = o_idle(); o.ready = 1'b0; o.mwe = 1'b1; o.maddr = a; o.mdata = d; return o;
  endfunction
  function automatic out_t o_push(input logic [15:0] a, input logic [7:0] d,
                                  input logic w, input logic [7:0] s);
    out_t o = o_mem(a, d); o.spwe = w; o.spo = s; return o;
  endfunction

  function automatic out_t sample();
    return '{ready:wb_ready, mwe:mem_we, maddr:mem_addr, mdata:mem_data,
             rwe:reg_we, rsel:reg_sel, rdata:reg_data, spwe:sp_we,
             spo:sp_out, done:instruction_done};
  endfunction

  task automatic check_out(input string name, input out_t exp);
    out_t act = sample();
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [1:0] m, input logic [3:0] d,
                         input logic [15:0] a, input logic [15:0] x, input logic [7:0] s,
                         input out_t e0, input out_t e1, input out_t e2, input out_t e3);
    vecs[i].mode = m; vecs[i].dest = d; vecs[i].addr = a;
    vecs[i].data = x; vecs[i].sp = s;
    vecs[i].exp[0] = e0; vecs[i].exp[1] = e1; vecs[i].exp[2] = e2; vecs[i].exp[3] = e3;
  endtask

  task automatic drive(input logic st, input logic [1:0] m, input logic [3:0] d,
                       input logic [15:0] a, input logic [15:0] x, input logic [7:0] s);
    wb_start = st; wb_mode = m; wb_dest = d; wb_addr = a; wb_data = x; sp_in = s;
  endtask

  initial begin
    int cnt_m, cnt_r, cnt_d, first, second;

    set_vec(0, 2'd0, 4'h2, 16'h0000, 16'h005A, 8'h00,
            o_reg(4'h2, 8'h5A), o_done(), o_idle(), o_idle());
    set_vec(1, 2'd1, 4'h0, 16'h0200, 16'h00C3, 8'h00,
            o_mem(16'h0200, 8'hC3), o_done(), o_idle(), o_idle());
    set_vec(2, 2'd3, 4'h0, 16'h0000, 16'h1234, 8'hFD,
            o_push(16'h01FD, 8'h12, 1'b0, 8'h00), o_push(16'h01FC, 8'h34, 1'b1, 8'hFB),
            o_done(), o_idle());
    set_vec(3, 2'd3, 4'h0, 16'h0000, 16'hABCD, 8'h00,
            o_push(16'h0100, 8'hAB, 1'b0, 8'h00), o_push(16'h01FF, 8'hCD, 1'b1, 8'hFE),
            o_done(), o_idle());
    set_vec(4, 2'd2, 4'h0, 16'h0000, 16'h0077, 8'h00,
            o_push(16'h0100, 8'h77, 1'b1, 8'hFF), o_done(), o_idle(), o_idle());
    set_vec(5, 2'd0, 4'hF, 16'h1234, 16'hEE11, 8'h55,
            o_reg(4'hF, 8'h11), o_done(), o_idle(), o_idle());
    set_vec(6, 2'd1, 4'h3, 16'hFFFF, 16'h5580, 8'h10,
            o_mem(16'hFFFF, 8'h80), o_done(), o_idle(), o_idle());
    set_vec(7, 2'd2, 4'h1, 16'h4444, 16'hAA42, 8'h80,
            o_push(16'h0180, 8'h42, 1'b1, 8'h7F), o_done(), o_idle(), o_idle());

    reset = 1'b1;
    drive(1'b0, 2'd0, 4'h0, 16'h0, 16'h0, 8'h0);
    repeat (3) @(posedge phi1);
    @(negedge phi1);
    check_out("reset_state", o_idle());
    reset = 1'b0;
    @(negedge phi1);

    // Table: accept on one edge, then inputs are scrambled to prove latching.
    for (int i = 0; i < NV; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].dest, vecs[i].addr, vecs[i].data, vecs[i].sp);
      @(negedge phi1);
      check_out($sformatf("vec%0d_c1", i), vecs[i].exp[0]);
      drive(1'b0, ~vecs[i].mode, ~vecs[i].dest, ~vecs[i].addr, ~vecs[i].data, ~vecs[i].sp);
      for (int c = 1; c < 4; c++) begin
        @(negedge phi1);
        check_out($sformatf("vec%0d_c%0d", i, c + 1), vecs[i].exp[c]);
      end
    end

    // Reset during PUSH_HI of a PUSH16: nothing further happens.
    drive(1'b1, 2'd3, 4'h0, 16'h0, 16'h1234, 8'hFD);
    @(negedge phi1);
    check_out("rst_push_hi_before", o_push(16'h01FD, 8'h12, 1'b0, 8'h00));
    drive(1'b0, 2'd0, 4'h0, 16'h0, 16'h0, 8'h0);
    reset = 1'b1;
    @(negedge phi1);
    reset = 1'b0;
    check_out("rst_push_after", o_idle());
    for (int c = 0; c < 3; c++) begin
      @(negedge phi1);
      check_out($sformatf("rst_push_quiet%0d", c), o_idle());
    end

    // wb_start during W_MEM is ignored.
    cnt_m = 0; cnt_r = 0; cnt_d = 0;
    drive(1'b1, 2'd1, 4'h0, 16'h0300, 16'h0099, 8'h00);
    for (int c = 1; c <= 6; c++) begin
      @(negedge phi1);
      if (c == 1) drive(1'b1, 2'd0, 4'h5, 16'h0, 16'h0011, 8'h00);
      else        drive(1'b0, 2'd0, 4'h0, 16'h0, 16'h0, 8'h0);
      cnt_m += int'(mem_we);
      cnt_r += int'(reg_we);
      cnt_d += int'(instruction_done);
    end
    check_int("ignore_mem_writes", cnt_m, 1);
    check_int("ignore_reg_writes", cnt_r, 0);
    check_int("ignore_done", cnt_d, 1);

    // Held wb_start: accepts are 3 cycles apart.
    first = -1; second = -1;
    drive(1'b1, 2'd0, 4'h7, 16'h0, 16'h0042, 8'h00);
    for (int c = 1; c <= 6; c++) begin
      @(negedge phi1);
      if (reg_we === 1'b1) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    drive(1'b0, 2'd0, 4'h0, 16'h0, 16'h0, 8'h0);
    check_int("held_first_write", first, 1);
    check_int("held_second_write", second, 4);
    repeat (3) @(negedge phi1);

    // Reset and wb_start together: reset wins.
    reset = 1'b1;
    drive(1'b1, 2'd0, 4'h3, 16'h0, 16'h00AB, 8'h00);
    @(negedge phi1);
    reset = 1'b0;
    drive(1'b0, 2'd0, 4'h0, 16'h0, 16'h0, 8'h0);
    check_out("rst_and_start", o_idle());
    @(negedge phi1);
    check_out("rst_and_start_dropped", o_idle());
    check_bit("rst_and_start_ready", wb_ready, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
